tdm_frame_collector: RTL



---
 rtl/tdm_pkg.sv | 27 ++
 rtl/tdm_dwell_timer.sv | 44 ++++
 rtl/tdm_frame_collector.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared types, widths and helpers for the TDM frame collector.
// Revision : 1.0
// ============================================================================
package tdm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int N_CH    = 8;
   localparam int CH_W    = 3;
   localparam int DWELL_W = 4;

   function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] ch);
      logic [N_CH-1:0] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : tdm_dwell_timer
// Purpose  : Dwell counter; ticks on the last cycle of each channel dwell.
// Revision : 1.0
// ============================================================================
module tdm_dwell_timer
   import tdm_pkg::*;
#(
   parameter int DWELL = 2
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iClr,
   input  logic iEn,
   output logic oTick
);

   localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;

   assign oTick = iEn && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (iClr) begin
         cnt_d = '0;
      end else if (iEn) begin
         cnt_d = oTick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tdm_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : tdm_frame_collector
// Purpose  : Scans 8 TDM channels, assembles a frame, flags idle-line faults.
// Revision : 1.0
// ============================================================================
module tdm_frame_collector
   import tdm_pkg::*;
#(
   parameter int DWELL = 2
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iStart,
   input  logic       iAbort,
   input  logic [7:0] iLink,
   input  logic       iReady,
   output logic       oA,
   output logic       oB,
   output logic       oC,
   output logic       oBusy,
   output logic       oValid,
   output logic [7:0] oFrame,
   output logic       oErr
);

   state_t          state_q;
   logic [CH_W-1:0] ch_q;
   logic [N_CH-1:0] shadow_q;
   logic            err_sh_q;
   logic [N_CH-1:0] frame_q;
   logic            err_q;
   logic            busy_q;
   logic            valid_q;

   logic            tick;
   logic [N_CH-1:0] sel_mask_d;
   logic [N_CH-1:0] shadow_d;
   logic            err_sh_d;

   tdm_dwell_timer #(.DWELL(DWELL)) u_timer (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iClr   ((state_q != SCAN) || iAbort),
      .iEn    (state_q == SCAN),
      .oTick  (tick)
   );

   // Sample of the selected line merged in, plus any idle line that reads low.
   assign sel_mask_d = onehot(ch_q);
   assign shadow_d   = shadow_q | (iLink & sel_mask_d);
   assign err_sh_d   = err_sh_q | (|(~iLink & ~sel_mask_d));

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q  <= IDLE;
         ch_q     <= '0;
         shadow_q <= '0;
         err_sh_q <= 1'b0;
         frame_q  <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (iStart) begin
                  state_q  <= SCAN;
                  ch_q     <= '0;
                  shadow_q <= '0;
                  err_sh_q <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            SCAN: begin
               if (iAbort) begin
                  state_q <= IDLE;
                  ch_q    <= '0;
                  busy_q  <= 1'b0;
               end else if (tick) begin
                  shadow_q <= shadow_d;
                  err_sh_q <= err_sh_d;
                  if (ch_q == CH_W'(N_CH - 1)) begin
                     frame_q <= shadow_d;
                     err_q   <= err_sh_d;
                     state_q <= HOLD;
                     ch_q    <= '0;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b1;
                  end else begin
                     ch_q <= ch_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (iReady) begin
                  valid_q <= 1'b0;
                  if (iStart) begin
                     state_q  <= SCAN;
                     ch_q     <= '0;
                     shadow_q <= '0;
                     err_sh_q <= 1'b0;
                     busy_q   <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               ch_q    <= '0;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign oA     = ch_q[2];
   assign oB     = ch_q[1];
   assign oC     = ch_q[0];
   assign oBusy  = busy_q;
   assign oValid = valid_q;
   assign oFrame = frame_q;
   assign oErr   = err_q;

endmodule
`default_nettype wire
